// File: rtl/ps2_pkg.sv
// ----------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the PS/2 keyboard controller:
//   - dec_state_t : scan-code decoder FSM states
//   - PFX_*       : set-2 prefix bytes (E0 extended, F0 break, E1 pause)
//   - KEY_*       : Hack keyboard codes for the non-printable keys
//   - ps2_to_hack : set-2 scan code -> Hack key code (0 = unmapped)
//   - apply_shift : shift-dependent remap, only with PS2_SHIFT_MAP_EN defined
// ----------------------------------------------------------------------------
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK,
        ST_SKIP
    } dec_state_t;

    localparam logic [7:0] PFX_E0 = 8'hE0;
    localparam logic [7:0] PFX_F0 = 8'hF0;
    localparam logic [7:0] PFX_E1 = 8'hE1;

    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;

    // Bytes that follow E1 in the pause sequence (E1 14 77 E1 F0 14 F0 77).
    localparam logic [2:0] PAUSE_SKIP = 3'd7;

    localparam logic [15:0] KEY_NONE   = 16'd0;
    localparam logic [15:0] KEY_SPACE  = 16'd32;
    localparam logic [15:0] KEY_ENTER  = 16'd128;
    localparam logic [15:0] KEY_BKSP   = 16'd129;
    localparam logic [15:0] KEY_LEFT   = 16'd130;
    localparam logic [15:0] KEY_UP     = 16'd131;
    localparam logic [15:0] KEY_RIGHT  = 16'd132;
    localparam logic [15:0] KEY_DOWN   = 16'd133;
    localparam logic [15:0] KEY_HOME   = 16'd134;
    localparam logic [15:0] KEY_END    = 16'd135;
    localparam logic [15:0] KEY_PGUP   = 16'd136;
    localparam logic [15:0] KEY_PGDN   = 16'd137;
    localparam logic [15:0] KEY_INSERT = 16'd138;
    localparam logic [15:0] KEY_DELETE = 16'd139;
    localparam logic [15:0] KEY_ESC    = 16'd140;
    localparam logic [15:0] KEY_F1     = 16'd141;

    // Letters come back upper-case and digits plain; the shift build adjusts
    // them afterwards with apply_shift.
    function automatic logic [15:0] ps2_to_hack(input logic [7:0] code,
                                                input logic       ext);
        logic [15:0] k;
        k = KEY_NONE;
        if (ext) begin
            case (code)
                8'h6B: k = KEY_LEFT;
                8'h75: k = KEY_UP;
                8'h74: k = KEY_RIGHT;
                8'h72: k = KEY_DOWN;
                8'h6C: k = KEY_HOME;
                8'h69: k = KEY_END;
                8'h7D: k = KEY_PGUP;
                8'h7A: k = KEY_PGDN;
                8'h70: k = KEY_INSERT;
                8'h71: k = KEY_DELETE;
                default: k = KEY_NONE;
            endcase
        end else begin
            case (code)
                8'h1C: k = 16'd65;  8'h32: k = 16'd66;  8'h21: k = 16'd67;
                8'h23: k = 16'd68;  8'h24: k = 16'd69;  8'h2B: k = 16'd70;
                8'h34: k = 16'd71;  8'h33: k = 16'd72;  8'h43: k = 16'd73;
                8'h3B: k = 16'd74;  8'h42: k = 16'd75;  8'h4B: k = 16'd76;
                8'h3A: k = 16'd77;  8'h31: k = 16'd78;  8'h44: k = 16'd79;
                8'h4D: k = 16'd80;  8'h15: k = 16'd81;  8'h2D: k = 16'd82;
                8'h1B: k = 16'd83;  8'h2C: k = 16'd84;  8'h3C: k = 16'd85;
                8'h2A: k = 16'd86;  8'h1D: k = 16'd87;  8'h22: k = 16'd88;
                8'h35: k = 16'd89;  8'h1A: k = 16'd90;
                8'h45: k = 16'd48;  8'h16: k = 16'd49;  8'h1E: k = 16'd50;
                8'h26: k = 16'd51;  8'h25: k = 16'd52;  8'h2E: k = 16'd53;
                8'h36: k = 16'd54;  8'h3D: k = 16'd55;  8'h3E: k = 16'd56;
                8'h46: k = 16'd57;
                8'h29: k = KEY_SPACE;
                8'h5A: k = KEY_ENTER;
                8'h66: k = KEY_BKSP;
                8'h76: k = KEY_ESC;
                8'h05: k = KEY_F1;          8'h06: k = KEY_F1 + 16'd1;
                8'h04: k = KEY_F1 + 16'd2;  8'h0C: k = KEY_F1 + 16'd3;
                8'h03: k = KEY_F1 + 16'd4;  8'h0B: k = KEY_F1 + 16'd5;
                8'h83: k = KEY_F1 + 16'd6;  8'h0A: k = KEY_F1 + 16'd7;
                8'h01: k = KEY_F1 + 16'd8;  8'h09: k = KEY_F1 + 16'd9;
                8'h78: k = KEY_F1 + 16'd10; 8'h07: k = KEY_F1 + 16'd11;
                default: k = KEY_NONE;
            endcase
        end
        return k;
    endfunction

`ifdef PS2_SHIFT_MAP_EN
    // Letters drop to lower case without shift; digits become ")!@#$%^&*(".
    function automatic logic [15:0] apply_shift(input logic [15:0] k,
                                                input logic        shift);
        logic [15:0] r;
        r = k;
        if (k >= 16'd65 && k <= 16'd90 && !shift) begin
            r = k + 16'd32;
        end else if (k >= 16'd48 && k <= 16'd57 && shift) begin
            case (k)
                16'd48: r = 16'd41;  16'd49: r = 16'd33;  16'd50: r = 16'd64;
                16'd51: r = 16'd35;  16'd52: r = 16'd36;  16'd53: r = 16'd37;
                16'd54: r = 16'd94;  16'd55: r = 16'd38;  16'd56: r = 16'd42;
                default: r = 16'd40;
            endcase
        end
        return r;
    endfunction
`endif

endpackage

// File: rtl/ps2_frame_rx.sv
// ----------------------------------------------------------------------------
// ps2_frame_rx
// Receives one 11-bit PS/2 frame (start 0, 8 data LSB first, odd parity,
// stop 1) and reports either a good byte or a dropped frame.
//   iCLK, iRST       system clock, synchronous active-high reset
//   iPS2CLK/iPS2DAT  raw asynchronous PS/2 lines
//   byte_data        received byte, valid while byte_vld is high
//   byte_vld         one-cycle pulse, the cycle after the stop-bit edge
//   frame_err        one-cycle pulse on bad parity/stop or on timeout
// ----------------------------------------------------------------------------
module ps2_frame_rx #(
    parameter int TIMEOUT = 50000
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic       iPS2CLK,
    input  logic       iPS2DAT,
    output logic [7:0] byte_data,
    output logic       byte_vld,
    output logic       frame_err
);

    localparam int TW = $clog2(TIMEOUT + 1);

    logic [1:0]    clk_sync;
    logic [1:0]    dat_sync;
    logic          clk_prev;
    logic          ps2_fall;
    logic [3:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          par_bit;
    logic [TW-1:0] to_cnt;

    assign ps2_fall  = clk_prev & ~clk_sync[1];
    assign byte_data = shreg;

    // NOTE: all state here uses non-blocking assignments so every flop samples
    // the values from before this edge, independent of statement order.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            clk_sync  <= 2'b11;
            dat_sync  <= 2'b11;
            clk_prev  <= 1'b1;
            bit_cnt   <= 4'd0;
            shreg     <= 8'd0;
            par_bit   <= 1'b0;
            to_cnt    <= '0;
            byte_vld  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            clk_sync  <= {clk_sync[0], iPS2CLK};
            dat_sync  <= {dat_sync[0], iPS2DAT};
            clk_prev  <= clk_sync[1];
            byte_vld  <= 1'b0;
            frame_err <= 1'b0;

            if (ps2_fall) begin
                to_cnt <= '0;
                if (bit_cnt == 4'd0) begin
                    // A start bit of 1 is line noise: stay waiting for a real start.
                    if (!dat_sync[1]) bit_cnt <= 4'd1;
                end else if (bit_cnt <= 4'd8) begin
                    shreg   <= {dat_sync[1], shreg[7:1]};
                    bit_cnt <= bit_cnt + 4'd1;
                end else if (bit_cnt == 4'd9) begin
                    par_bit <= dat_sync[1];
                    bit_cnt <= 4'd10;
                end else begin
                    bit_cnt <= 4'd0;
                    if (dat_sync[1] && (^{shreg, par_bit})) byte_vld  <= 1'b1;
                    else                                    frame_err <= 1'b1;
                end
            end else if (bit_cnt != 4'd0) begin
                // Reaching TIMEOUT-1 here means this is the TIMEOUT-th quiet cycle.
                if (to_cnt == TW'(TIMEOUT - 1)) begin
                    bit_cnt   <= 4'd0;
                    to_cnt    <= '0;
                    frame_err <= 1'b1;
                end else begin
                    to_cnt <= to_cnt + 1'b1;
                end
            end else begin
                to_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/ps2_kbd_ctrl.sv
// ----------------------------------------------------------------------------
// ps2_kbd_ctrl
// PS/2 set-2 keyboard to Hack keyboard-register bridge.
//   iCLK, iRST       system clock, synchronous active-high reset
//   iPS2CLK/iPS2DAT  raw asynchronous PS/2 lines
//   oKEY             Hack code of the key currently held, 0 when none
//   oSTB             one-cycle pulse whenever oKEY changes
//   oERRCNT          saturating count of dropped frames
// Build option: define PS2_SHIFT_MAP_EN to track left/right shift and emit
// lower-case letters / shifted digit symbols.
// ----------------------------------------------------------------------------
module ps2_kbd_ctrl
    import ps2_pkg::*;
#(
    parameter int TIMEOUT = 50000,
    parameter int ERRW    = 8
) (
    input  logic            iCLK,
    input  logic            iRST,
    input  logic            iPS2CLK,
    input  logic            iPS2DAT,
    output logic [15:0]     oKEY,
    output logic            oSTB,
    output logic [ERRW-1:0] oERRCNT
);

    logic [7:0]  rx_byte;
    logic        rx_vld;
    logic        rx_err;

    dec_state_t  state, state_nxt;
    logic [2:0]  skip_cnt, skip_nxt;
    logic [15:0] key_nxt;
    logic        stb_nxt;
    logic        ev_hit, ev_ext, ev_brk;
    logic [15:0] base_code, make_code, alt_code;
`ifdef PS2_SHIFT_MAP_EN
    logic        shift_l, shift_r, shift_l_nxt, shift_r_nxt;
`endif

    ps2_frame_rx #(.TIMEOUT(TIMEOUT)) u_rx (
        .iCLK      (iCLK),
        .iRST      (iRST),
        .iPS2CLK   (iPS2CLK),
        .iPS2DAT   (iPS2DAT),
        .byte_data (rx_byte),
        .byte_vld  (rx_vld),
        .frame_err (rx_err)
    );

    // State register: decoder state plus the registered key outputs.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state    <= ST_IDLE;
            skip_cnt <= 3'd0;
            oKEY     <= KEY_NONE;
            oSTB     <= 1'b0;
`ifdef PS2_SHIFT_MAP_EN
            shift_l  <= 1'b0;
            shift_r  <= 1'b0;
`endif
        end else begin
            state    <= state_nxt;
            skip_cnt <= skip_nxt;
            oKEY     <= key_nxt;
            oSTB     <= stb_nxt;
`ifdef PS2_SHIFT_MAP_EN
            shift_l  <= shift_l_nxt;
            shift_r  <= shift_r_nxt;
`endif
        end
    end

    // Next-state logic: prefixes steer the FSM, anything else ends the code.
    always_comb begin
        // NOTE: default assignment first so no path leaves a variable unassigned,
        // which would otherwise infer a latch.
        state_nxt = state;
        if (rx_vld) begin
            case (state)
                ST_IDLE: begin
                    if      (rx_byte == PFX_E0) state_nxt = ST_EXT;
                    else if (rx_byte == PFX_F0) state_nxt = ST_BRK;
                    else if (rx_byte == PFX_E1) state_nxt = ST_SKIP;
                end
                ST_EXT:     state_nxt = (rx_byte == PFX_F0) ? ST_EXT_BRK : ST_IDLE;
                ST_BRK:     state_nxt = ST_IDLE;
                ST_EXT_BRK: state_nxt = ST_IDLE;
                ST_SKIP:    if (skip_cnt == 3'd1) state_nxt = ST_IDLE;
                default:    state_nxt = ST_IDLE;
            endcase
        end
    end

    // Output logic: turn a completed make/break into the next oKEY value.
    always_comb begin
        key_nxt  = oKEY;
        stb_nxt  = 1'b0;
        skip_nxt = skip_cnt;
        ev_hit   = 1'b0;
`ifdef PS2_SHIFT_MAP_EN
        shift_l_nxt = shift_l;
        shift_r_nxt = shift_r;
`endif
        if (rx_vld) begin
            case (state)
                ST_IDLE: begin
                    if (rx_byte == PFX_E1) skip_nxt = PAUSE_SKIP;
                    else ev_hit = (rx_byte != PFX_E0) && (rx_byte != PFX_F0);
                end
                ST_EXT:     ev_hit = (rx_byte != PFX_F0);
                ST_BRK:     ev_hit = 1'b1;
                ST_EXT_BRK: ev_hit = 1'b1;
                ST_SKIP:    skip_nxt = skip_cnt - 3'd1;
                default:    ev_hit = 1'b0;
            endcase
        end

        ev_ext    = (state == ST_EXT) || (state == ST_EXT_BRK);
        ev_brk    = (state == ST_BRK) || (state == ST_EXT_BRK);
        base_code = ps2_to_hack(rx_byte, ev_ext);
`ifdef PS2_SHIFT_MAP_EN
        make_code = apply_shift(base_code, shift_l | shift_r);
        // A break matches either case so a key pressed before a shift change
        // is still released.
        alt_code  = apply_shift(base_code, ~(shift_l | shift_r));
        if (ev_hit && !ev_ext && rx_byte == SC_LSHIFT) shift_l_nxt = ~ev_brk;
        if (ev_hit && !ev_ext && rx_byte == SC_RSHIFT) shift_r_nxt = ~ev_brk;
`else
        make_code = base_code;
        alt_code  = base_code;
`endif

        if (ev_hit && make_code != KEY_NONE) begin
            if (!ev_brk) begin
                key_nxt = make_code;
                stb_nxt = (make_code != oKEY);
            end else if (oKEY == make_code || oKEY == alt_code) begin
                key_nxt = KEY_NONE;
                stb_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            oERRCNT <= '0;
        end else if (rx_err && oERRCNT != '1) begin
            oERRCNT <= oERRCNT + 1'b1;
        end
    end

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ps2_kbd_ctrl
// Drives PS/2 frames into ps2_kbd_ctrl and compares oKEY / strobe count /
// oERRCNT against a flag-based model of the set-2 protocol and key table.
// ----------------------------------------------------------------------------
module tb_ps2_kbd_ctrl;

    localparam int TO     = 300;
    localparam int EW     = 3;
    localparam int ERRMAX = (1 << EW) - 1;
    localparam int HP     = 6;
    localparam int GAP    = 12;

    logic          iCLK = 1'b0;
    logic          iRST = 1'b1;
    logic          iPS2CLK = 1'b1;
    logic          iPS2DAT = 1'b1;
    logic [15:0]   oKEY;
    logic          oSTB;
    logic [EW-1:0] oERRCNT;

    ps2_kbd_ctrl #(.TIMEOUT(TO), .ERRW(EW)) dut (
        .iCLK    (iCLK),
        .iRST    (iRST),
        .iPS2CLK (iPS2CLK),
        .iPS2DAT (iPS2DAT),
        .oKEY    (oKEY),
        .oSTB    (oSTB),
        .oERRCNT (oERRCNT)
    );

    always #5 iCLK = ~iCLK;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Strobe monitor: counts pulses and any key change that arrives without one.
    int          stb_seen = 0;
    int          silent_changes = 0;
    logic [15:0] prev_key = 16'd0;
    always @(negedge iCLK) begin
        if (oSTB) stb_seen++;
        if (!iRST && oKEY !== prev_key && !oSTB) silent_changes++;
        prev_key = oKEY;
    end

    // Key tables, indexed by position in the Hack code range.
    logic [7:0] letters [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
                                 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D,
                                 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22,
                                 8'h35, 8'h1A};
    logic [7:0] digits  [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                                 8'h3E, 8'h46};
    logic [7:0] fkeys   [12] = '{8'h05, 8'h06, 8'h04, 8'h0C, 8'h03, 8'h0B, 8'h83, 8'h0A,
                                 8'h01, 8'h09, 8'h78, 8'h07};
    logic [7:0] navs    [10] = '{8'h6B, 8'h75, 8'h74, 8'h72, 8'h6C, 8'h69, 8'h7D, 8'h7A,
                                 8'h70, 8'h71};
    int         sdigits [10] = '{41, 33, 64, 35, 36, 37, 94, 38, 42, 40};

    function automatic int ref_map(input logic [7:0] b, input bit ext, input bit shift);
        if (ext) begin
            for (int i = 0; i < 10; i++) if (navs[i] == b) return 130 + i;
            return 0;
        end
        for (int i = 0; i < 26; i++) if (letters[i] == b) begin
`ifdef PS2_SHIFT_MAP_EN
            return shift ? 65 + i : 97 + i;
`else
            return 65 + i;
`endif
        end
        for (int i = 0; i < 10; i++) if (digits[i] == b) begin
`ifdef PS2_SHIFT_MAP_EN
            return shift ? sdigits[i] : 48 + i;
`else
            return 48 + i;
`endif
        end
        for (int i = 0; i < 12; i++) if (fkeys[i] == b) return 141 + i;
        case (b)
            8'h29:   return 32;
            8'h5A:   return 128;
            8'h66:   return 129;
            8'h76:   return 140;
            default: return 0;
        endcase
    endfunction

    // Reference model: pending-prefix flags and a pause-skip countdown.
    int m_key, m_err, m_stb, m_skip, stb_base;
    bit m_ext, m_brk, m_shl, m_shr;

    task automatic model_clear();
        m_key = 0; m_err = 0; m_stb = 0; m_skip = 0;
        m_ext = 0; m_brk = 0; m_shl = 0; m_shr = 0;
        stb_base = stb_seen;
    endtask

    task automatic model_byte(input logic [7:0] b);
        bit ext, brk;
        int k, alt;
        if (m_skip > 0) begin m_skip--; return; end
        if (!m_brk) begin
            if (b == 8'hF0) begin m_brk = 1; return; end
            if (!m_ext && b == 8'hE0) begin m_ext = 1; return; end
            if (!m_ext && b == 8'hE1) begin m_skip = 7; return; end
        end
        ext = m_ext; brk = m_brk; m_ext = 0; m_brk = 0;
`ifdef PS2_SHIFT_MAP_EN
        if (!ext && (b == 8'h12 || b == 8'h59)) begin
            if (b == 8'h12) m_shl = !brk; else m_shr = !brk;
            return;
        end
        alt = ref_map(b, ext, !(m_shl || m_shr));
`endif
        k = ref_map(b, ext, m_shl || m_shr);
`ifndef PS2_SHIFT_MAP_EN
        alt = k;
`endif
        if (k == 0) return;
        if (!brk) begin
            if (k != m_key) begin m_key = k; m_stb++; end
        end else if (m_key == k || m_key == alt) begin
            m_key = 0; m_stb++;
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge iCLK);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              input int nbits, input int hold);
        logic [10:0] f;
        f = {~bad_stop, (~(^b)) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            iPS2DAT = f[i];
            tick(HP);
            iPS2CLK = 1'b0;
            tick(HP);
            iPS2CLK = 1'b1;
            if (i == 4) tick(hold);
        end
        iPS2DAT = 1'b1;
        tick(GAP);
    endtask

    task automatic verify(input string tag);
        check({tag, " key"}, oKEY, m_key);
        check({tag, " stb"}, stb_seen - stb_base, m_stb);
        check({tag, " err"}, oERRCNT, m_err);
    endtask

    // bad: 0 good frame, 1 parity error, 2 stop error.
    task automatic xfer(input logic [7:0] b, input int bad, input int hold, input string tag);
        send_frame(b, bad == 1, bad == 2, 11, hold);
        if (bad != 0) m_err = (m_err == ERRMAX) ? ERRMAX : m_err + 1;
        else          model_byte(b);
        verify(tag);
    endtask

    task automatic trunc(input logic [7:0] b, input int nbits, input string tag);
        send_frame(b, 0, 0, nbits, 0);
        tick(TO + 50);
        m_err = (m_err == ERRMAX) ? ERRMAX : m_err + 1;
        verify(tag);
    endtask

    task automatic do_reset();
        iRST = 1'b1;
        tick(3);
        check("rst key", oKEY, 0);
        check("rst stb", oSTB, 0);
        check("rst err", oERRCNT, 0);
        iRST = 1'b0;
        model_clear();
        tick(2);
    endtask

    function automatic logic [7:0] pick_mapped();
        case ($urandom_range(0, 3))
            0:       return letters[$urandom_range(0, 25)];
            1:       return digits[$urandom_range(0, 9)];
            2:       return fkeys[$urandom_range(0, 11)];
            default: return navs[$urandom_range(0, 9)];
        endcase
    endfunction

    logic [7:0] pause_seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};

    initial begin
        logic [7:0] last_code;
        int r;

        tick(2);
        do_reset();

        // Plain make then break of A.
        xfer(8'h1C, 0, 0, "A make");
        check("A make const", oKEY, 65);
        check("A make one stb", stb_seen - stb_base, 1);
        xfer(8'hF0, 0, 0, "A F0");
        xfer(8'h1C, 0, 0, "A break");
        check("A break const", oKEY, 0);
        check("A break stb", stb_seen - stb_base, 2);

        // Extended up arrow; non-extended 75 is keypad and stays unmapped.
        do_reset();
        xfer(8'hE0, 0, 0, "up E0");
        xfer(8'h75, 0, 0, "up make");
        check("up make const", oKEY, 131);
        xfer(8'hE0, 0, 0, "up E0b");
        xfer(8'hF0, 0, 0, "up F0");
        xfer(8'h75, 0, 0, "up break");
        check("up break const", oKEY, 0);
        xfer(8'h75, 0, 0, "kp8 make");
        check("kp8 ignored", oKEY, 0);

        // Parity and stop errors.
        do_reset();
        xfer(8'h1C, 1, 0, "bad parity");
        check("bad parity err const", oERRCNT, 1);
        check("bad parity key const", oKEY, 0);
        xfer(8'h1C, 2, 0, "bad stop");

        // Timeout on a partial frame, then a good space.
        do_reset();
        trunc(8'h1C, 5, "timeout");
        xfer(8'h29, 0, 0, "space after timeout");
        check("timeout err const", oERRCNT, 1);
        check("space const", oKEY, 32);

        // Pause sequence has no effect, then A.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            xfer(pause_seq[i], 0, 0, $sformatf("pause[%0d]", i));
            check($sformatf("pause[%0d] const", i), oKEY, 0);
        end
        xfer(8'h1C, 0, 0, "A after pause");
        check("A after pause const", oKEY, 65);

        // A start bit sampled as 1 is ignored: no frame, no timeout.
        iPS2DAT = 1'b1; tick(HP); iPS2CLK = 1'b0; tick(HP); iPS2CLK = 1'b1;
        tick(TO + 50);
        verify("start-1 glitch");

        // A pause shorter than TIMEOUT mid-frame does not abort it.
        xfer(8'h32, 0, TO / 2, "slow B");

        // Reset mid-frame discards the frame without an error.
        send_frame(8'h1C, 0, 0, 5, 0);
        do_reset();
        tick(TO + 50);
        check("mid-frame reset err", oERRCNT, 0);
        xfer(8'h1C, 0, 0, "A after reset");

`ifdef PS2_SHIFT_MAP_EN
        do_reset();
        xfer(8'h12, 0, 0, "lshift make");
        xfer(8'h1C, 0, 0, "shift A");
        check("shift A const", oKEY, 65);
        xfer(8'hF0, 0, 0, "A F0");
        xfer(8'h1C, 0, 0, "A break");
        xfer(8'hF0, 0, 0, "shift F0");
        xfer(8'h12, 0, 0, "lshift break");
        xfer(8'h1C, 0, 0, "lower a");
        check("lower a const", oKEY, 97);
`endif

        // Random traffic against the model.
        do_reset();
        last_code = 8'h1C;
        for (int n = 0; n < 200; n++) begin
            r = $urandom_range(0, 99);
            if (r < 15)      xfer($urandom_range(0, 1) ? 8'hE0 : 8'hF0, 0, 0, $sformatf("rnd%0d pfx", n));
            else if (r < 17) xfer(8'hE1, 0, 0, $sformatf("rnd%0d e1", n));
            else if (r < 70) begin
                last_code = pick_mapped();
                xfer(last_code, 0, 0, $sformatf("rnd%0d code", n));
            end
            else if (r < 80) xfer(8'($urandom_range(0, 255)), 0, 0, $sformatf("rnd%0d byte", n));
            else if (r < 88) xfer(8'($urandom_range(0, 255)), $urandom_range(1, 2), 0, $sformatf("rnd%0d bad", n));
            else if (r < 90) trunc(8'($urandom_range(0, 255)), $urandom_range(2, 10), $sformatf("rnd%0d trunc", n));
            else             xfer(last_code, 0, 0, $sformatf("rnd%0d repeat", n));
        end

        // Error counter saturates at all-ones.
        for (int i = 0; i < ERRMAX + 2; i++) xfer(8'h1C, 1, 0, $sformatf("sat%0d", i));
        check("err saturated", oERRCNT, ERRMAX);

        check("key change without stb", silent_changes, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
